// File: rtl/time_set_ctrl.sv
// Button-driven time-entry controller: snapshots the running time, edits
// hours/minutes/seconds with wrap and auto-repeat, then issues one load pulse.
module time_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] hours_cur,
    input  logic [5:0] mins_cur,
    input  logic [5:0] secs_cur,
    output logic [4:0] hours_o,
    output logic [5:0] mins_o,
    output logic [5:0] secs_o,
    output logic       start,
    output logic       editing,
    output logic [1:0] field_o
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_S  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t           state;
    logic             prev_mode;
    logic             prev_up;
    logic             prev_down;
    logic [CNT_W-1:0] rpt_cnt;

    logic mode_edge;
    logic up_edge;
    logic down_edge;
    logic one_held;
    logic in_set;
    logic step_inc;
    logic step_dec;

    assign mode_edge = btn_mode & ~prev_mode;
    assign up_edge   = btn_up & ~prev_up;
    assign down_edge = btn_down & ~prev_down;
    assign one_held  = btn_up ^ btn_down;
    assign in_set    = (state == SET_H) || (state == SET_M) || (state == SET_S);

    // Step request: a lone up/down edge, or an auto-repeat tick while one button is held.
    always_comb begin
        step_inc = 1'b0;
        step_dec = 1'b0;
        if (in_set && !mode_edge) begin
            if (up_edge ^ down_edge) begin
                step_inc = up_edge;
                step_dec = down_edge;
            end else if (!up_edge && !down_edge && one_held && (rpt_cnt == CNT_W'(1))) begin
                step_inc = btn_up;
                step_dec = btn_down;
            end
        end
    end

    function automatic logic [4:0] hours_step(input logic [4:0] h, input logic inc);
        if (inc) begin
            return (h == 5'd23) ? 5'd0 : h + 5'd1;
        end
        return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] sixty_step(input logic [5:0] v, input logic inc);
        if (inc) begin
            return (v == 6'd59) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hours_o   <= 5'd0;
            mins_o    <= 6'd0;
            secs_o    <= 6'd0;
            start     <= 1'b0;
            editing   <= 1'b0;
            field_o   <= 2'd0;
            rpt_cnt   <= '0;
            prev_mode <= 1'b1;
            prev_up   <= 1'b1;
            prev_down <= 1'b1;
        end else begin
            prev_mode <= btn_mode;
            prev_up   <= btn_up;
            prev_down <= btn_down;
            start     <= 1'b0;

            // Repeat counter counts down to the next auto-step; 0 means no run in progress.
            if (!in_set || mode_edge || !one_held) begin
                rpt_cnt <= '0;
            end else if (up_edge ^ down_edge) begin
                rpt_cnt <= CNT_W'(REPEAT_DELAY);
            end else if (rpt_cnt == CNT_W'(1)) begin
                rpt_cnt <= CNT_W'(REPEAT_RATE);
            end else if (rpt_cnt != '0) begin
                rpt_cnt <= rpt_cnt - CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (mode_edge) begin
                        state   <= SET_H;
                        editing <= 1'b1;
                        field_o <= 2'd1;
                        hours_o <= (hours_cur > 5'd23) ? 5'd0 : hours_cur;
                        mins_o  <= (mins_cur > 6'd59) ? 6'd0 : mins_cur;
                        secs_o  <= (secs_cur > 6'd59) ? 6'd0 : secs_cur;
                    end
                end
                SET_H: begin
                    if (mode_edge) begin
                        state   <= SET_M;
                        field_o <= 2'd2;
                    end else if (step_inc || step_dec) begin
                        hours_o <= hours_step(hours_o, step_inc);
                    end
                end
                SET_M: begin
                    if (mode_edge) begin
                        state   <= SET_S;
                        field_o <= 2'd3;
                    end else if (step_inc || step_dec) begin
                        mins_o <= sixty_step(mins_o, step_inc);
                    end
                end
                SET_S: begin
                    if (mode_edge) begin
                        state   <= COMMIT;
                        editing <= 1'b0;
                        field_o <= 2'd0;
                        start   <= 1'b1;
                    end else if (step_inc || step_dec) begin
                        secs_o <= sixty_step(secs_o, step_inc);
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    editing <= 1'b0;
                    field_o <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed table, hand sequences and
// randomized buttons against a cycle-time based reference model.
module tb_time_set_ctrl;

    localparam int REP_D = 5;
    localparam int REP_R = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [4:0] hours_cur;
    logic [5:0] mins_cur;
    logic [5:0] secs_cur;
    logic [4:0] hours_o;
    logic [5:0] mins_o;
    logic [5:0] secs_o;
    logic       start;
    logic       editing;
    logic [1:0] field_o;

    time_set_ctrl #(.REPEAT_DELAY(REP_D), .REPEAT_RATE(REP_R)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .hours_cur (hours_cur),
        .mins_cur  (mins_cur),
        .secs_cur  (secs_cur),
        .hours_o   (hours_o),
        .mins_o    (mins_o),
        .secs_o    (secs_o),
        .start     (start),
        .editing   (editing),
        .field_o   (field_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;

    // Pulses are counted on the edge that follows the high cycle.
    always @(posedge clk) if (start) start_cnt++;

    // Reference model: phase 0 idle, 1..3 editing h/m/s, 4 commit.
    int m_phase, m_h, m_m, m_s, m_cyc, m_t;
    bit m_pm, m_pu, m_pd, m_run;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int eh, input int em, input int es,
                             input int est, input int ef);
        check({tag, ".hours"},   int'(hours_o), eh);
        check({tag, ".mins"},    int'(mins_o), em);
        check({tag, ".secs"},    int'(secs_o), es);
        check({tag, ".start"},   int'(start), est);
        check({tag, ".field"},   int'(field_o), ef);
        check({tag, ".editing"}, int'(editing), (ef != 0) ? 1 : 0);
    endtask

    task automatic model_update(input bit m, input bit u, input bit d, input bit r);
        bit me, ue, de, one, insel;
        int dir, k;
        if (r) begin
            m_phase = 0; m_h = 0; m_m = 0; m_s = 0;
            m_pm = 1; m_pu = 1; m_pd = 1; m_run = 0;
        end else begin
            me = m & ~m_pm;
            ue = u & ~m_pu;
            de = d & ~m_pd;
            insel = (m_phase >= 1) && (m_phase <= 3);
            one = u ^ d;
            dir = 0;
            if (insel && !me) begin
                if (ue ^ de) begin
                    dir = ue ? 1 : -1;
                    m_run = one;
                    m_t = m_cyc;
                end else if (!ue && !de && one && m_run) begin
                    k = m_cyc - m_t;
                    if (k == REP_D || (k > REP_D && (k - REP_D) % REP_R == 0))
                        dir = u ? 1 : -1;
                end
            end
            if (!insel || me || !one) m_run = 0;
            if (dir != 0) begin
                case (m_phase)
                    1: m_h = (m_h + 24 + dir) % 24;
                    2: m_m = (m_m + 60 + dir) % 60;
                    3: m_s = (m_s + 60 + dir) % 60;
                    default: ;
                endcase
            end
            if (m_phase == 4) begin
                m_phase = 0;
            end else if (me) begin
                if (m_phase == 0) begin
                    m_h = (int'(hours_cur) > 23) ? 0 : int'(hours_cur);
                    m_m = (int'(mins_cur) > 59) ? 0 : int'(mins_cur);
                    m_s = (int'(secs_cur) > 59) ? 0 : int'(secs_cur);
                end
                m_phase++;
            end
            m_pm = m; m_pu = u; m_pd = d;
        end
        m_cyc++;
    endtask

    // Drive at the falling edge, clock once, return at the next falling edge.
    task automatic step(input bit m, input bit u, input bit d, input bit r);
        btn_mode = m; btn_up = u; btn_down = d; reset = r;
        @(posedge clk);
        model_update(m, u, d, r);
        @(negedge clk);
    endtask

    typedef struct {
        bit m, u, d;
        int eh, em, es, est, ef;
    } vec_t;

    vec_t tbl[12];
    int   exp_rep[10];
    bit   rm, ru, rd, rr;
    int   pulses_before;

    initial begin
        reset = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        hours_cur = 5'd0; mins_cur = 6'd0; secs_cur = 6'd0;
        m_cyc = 0; m_t = 0;
        @(negedge clk);

        // Reset with up held: no step once reset drops.
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        check_out("reset", 0, 0, 0, 0, 0);
        step(0, 1, 0, 0);
        check_out("post_reset", 0, 0, 0, 0, 0);

        // Snapshot, edit, commit.
        hours_cur = 5'd10; mins_cur = 6'd30; secs_cur = 6'd15;
        step(1, 0, 0, 0);
        check_out("snap", 10, 30, 15, 0, 1);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            check("hours_up", int'(hours_o), 11 + i);
            step(0, 0, 0, 0);
        end
        step(1, 0, 0, 0);
        check_out("to_min", 13, 30, 15, 0, 2);
        step(0, 0, 0, 0);
        for (int i = 0; i < 31; i++) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        check_out("min_under", 13, 59, 15, 0, 2);
        step(1, 0, 0, 0);
        check_out("to_sec", 13, 59, 15, 0, 3);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check_out("commit", 13, 59, 15, 1, 0);
        step(0, 0, 0, 0);
        check_out("after_commit", 13, 59, 15, 0, 0);
        check("start_pulses", start_cnt, 1);

        // Wrap, clamp and mode/up collision table.
        tbl[0]  = '{1'b1, 1'b0, 1'b0,  0, 59, 59, 0, 1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 23, 59, 59, 0, 1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 23, 59, 59, 0, 1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0,  0, 59, 59, 0, 1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0,  0, 59, 59, 0, 1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0,  1, 59, 59, 0, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0,  1, 59, 59, 0, 1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0,  1, 59, 59, 0, 2};
        tbl[8]  = '{1'b0, 1'b0, 1'b0,  1, 59, 59, 0, 2};
        tbl[9]  = '{1'b1, 1'b0, 1'b0,  1, 59, 59, 0, 3};
        tbl[10] = '{1'b0, 1'b1, 1'b0,  1, 59,  0, 0, 3};
        tbl[11] = '{1'b0, 1'b0, 1'b0,  1, 59,  0, 0, 3};
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        hours_cur = 5'd24; mins_cur = 6'd59; secs_cur = 6'd59;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].m, tbl[i].u, tbl[i].d, 0);
            check_out($sformatf("tbl%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].est, tbl[i].ef);
        end

        // Abort from SET_S: edits dropped, no pulse.
        pulses_before = start_cnt;
        step(0, 0, 0, 1);
        check_out("abort", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        check_out("abort_idle", 0, 0, 0, 0, 0);
        check("abort_pulses", start_cnt, pulses_before);

        // Auto-repeat in SET_M from 0: steps at +0, +5, +7, +9.
        exp_rep = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4};
        hours_cur = 5'd0; mins_cur = 6'd0; secs_cur = 6'd0;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, 0);
            check($sformatf("rep%0d", k), int'(mins_o), exp_rep[k]);
        end
        step(0, 0, 0, 0);
        check("rep_release", int'(mins_o), 4);
        for (int k = 0; k < 8; k++) step(0, 1, 1, 0);
        check_out("both_held", 0, 4, 0, 0, 2);
        step(0, 0, 0, 0);

        // Randomized run against the model.
        step(0, 0, 0, 1);
        ru = 0; rd = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) ru = ~ru;
            if ($urandom_range(0, 9) == 0) rd = ~rd;
            rm = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 599) == 0);
            hours_cur = 5'($urandom_range(0, 31));
            mins_cur  = 6'($urandom_range(0, 63));
            secs_cur  = 6'($urandom_range(0, 63));
            step(rm, ru, rd, rr);
            check_out("rnd", m_h, m_m, m_s, (m_phase == 4) ? 1 : 0,
                      (m_phase >= 1 && m_phase <= 3) ? m_phase : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
